imem_loader: RTL and testbench

//  Writer side of the instruction memory. Receives a program as a byte stream

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory types and constants
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0] NOP_BYTE   = 8'h00;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program image byte-wise into instruction memory
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    if (MEM_BYTES % WORD_BYTES != 0) begin : g_bad_mem_bytes
        $error("imem_loader: MEM_BYTES must be a multiple of the word size");
    end
    if (MEM_BYTES > (1 << ADDR_W)) begin : g_bad_addr_w
        $error("imem_loader: MEM_BYTES does not fit in ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_BYTES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                core_hold_q, core_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;
    logic                word_end;

    assign accept   = in_valid & in_ready_q;
    // ptr is on the last byte of a word, i.e. (ptr+1) % 4 == 0
    assign word_end = (ptr_q[1:0] == 2'(WORD_BYTES - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_data;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    count_d   = count_q + (ADDR_W + 1)'(1);
                    if (in_last) begin
                        state_d = word_end ? DONE : PAD;
                    end else if (ptr_q == LAST_PTR) begin
                        state_d = ERR;
                    end
                end
            end
            PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = NOP_BYTE;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (word_end) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == LOAD);
        // done lags entry into DONE by a cycle so the final write lands first
        done_d      = (state_q == DONE) && (state_d == DONE);
        error_d     = (state_d == ERR);
        core_hold_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MEM_BYTES = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   byte_count;

    imem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_wr_cyc = 0;
    int ptr_m  = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected {addr,data}
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[15:8]));
                check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ptr_m = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit gap);
        bit ok;
        if (gap) begin
            in_valid = 1'b0; in_data = 8'hEE; in_last = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = d; in_last = last;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 0, 1);
        else begin
            exp_q.push_back({ptr_m[7:0], d});
            ptr_m++;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic push_pad();
        while (ptr_m % 4 != 0) begin
            exp_q.push_back({ptr_m[7:0], 8'h00});
            ptr_m++;
        end
    endtask

    task automatic wait_flag(output int seen);
        bit hit;
        hit = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                hit = 1'b1;
                seen = cyc;
                break;
            end
        end
        if (!hit) check("flag_timeout", 0, 1);
        @(negedge clk);
    endtask

    typedef struct {
        string        name;
        logic [127:0] bytes;
        int           n;
        bit           last;
        bit           exp_err;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;

        vecs[0] = '{"aligned8", {64'h8C01_0000_8C02_0001, 64'h0}, 8, 1'b1, 1'b0};
        vecs[1] = '{"pad6", {48'h0022_0818_0800, 80'h0}, 6, 1'b1, 1'b0};
        vecs[2] = '{"overflow", 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16, 1'b0, 1'b1};

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_core_hold", 32'(core_hold), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_byte_count", 32'(byte_count), 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_reset();
            pulse_start();
            for (int b = 0; b < vecs[i].n; b++) begin
                send_byte(vecs[i].bytes[127 - 8*b -: 8], vecs[i].last && (b == vecs[i].n - 1), 1'b0);
            end
            if (vecs[i].last) push_pad();
            wait_flag(seen);
            check({vecs[i].name, "_queue_drained"}, 32'(exp_q.size()), 0);
            check({vecs[i].name, "_byte_count"}, 32'(byte_count), 32'(vecs[i].n));
            check({vecs[i].name, "_done"}, 32'(done), 32'(!vecs[i].exp_err));
            check({vecs[i].name, "_error"}, 32'(error), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_core_hold"}, 32'(core_hold), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_in_ready"}, 32'(in_ready), 0);
            if (!vecs[i].exp_err)
                check({vecs[i].name, "_done_latency"}, 32'(seen - last_wr_cyc), 1);
            @(posedge clk); #1;
        end

        // ERR -> start restarts a load with cleared counters
        pulse_start();
        @(negedge clk);
        check("err_restart_byte_count", 32'(byte_count), 0);
        check("err_restart_error", 32'(error), 0);
        check("err_restart_in_ready", 32'(in_ready), 1);
        check("err_restart_core_hold", 32'(core_hold), 1);
        @(posedge clk); #1;

        // Backpressure: valid low on alternate cycles
        send_byte(8'hA1, 1'b0, 1'b1);
        send_byte(8'hA2, 1'b0, 1'b1);
        send_byte(8'hA3, 1'b0, 1'b1);
        send_byte(8'hA4, 1'b1, 1'b1);
        wait_flag(seen);
        check("bp_queue_drained", 32'(exp_q.size()), 0);
        check("bp_byte_count", 32'(byte_count), 4);
        check("bp_done", 32'(done), 1);
        check("bp_done_latency", 32'(seen - last_wr_cyc), 1);
        @(posedge clk); #1;

        // Reload from DONE: core_hold rises on the start edge
        start = 1'b1;
        @(negedge clk);
        check("pre_start_core_hold", 32'(core_hold), 0);
        @(posedge clk); #1;
        start = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        check("reload_core_hold", 32'(core_hold), 1);
        check("reload_done", 32'(done), 0);
        check("reload_byte_count", 32'(byte_count), 0);
        @(posedge clk); #1;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        wait_flag(seen);
        check("reload_queue_drained", 32'(exp_q.size()), 0);
        check("reload_done_again", 32'(done), 1);
        check("reload_core_released", 32'(core_hold), 0);
        @(posedge clk); #1;

        // Reset in the middle of a load
        pulse_start();
        send_byte(8'h51, 1'b0, 1'b0);
        send_byte(8'h52, 1'b0, 1'b0);
        send_byte(8'h53, 1'b0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'h99; in_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_wr_addr", 32'(wr_addr), 0);
        check("midrst_wr_data", 32'(wr_data), 0);
        check("midrst_core_hold", 32'(core_hold), 1);
        check("midrst_done", 32'(done), 0);
        check("midrst_error", 32'(error), 0);
        check("midrst_byte_count", 32'(byte_count), 0);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_queue_drained", 32'(exp_q.size()), 0);
        check("midrst_idle_byte_count", 32'(byte_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
